dcu_window_display: RTL and testbench

//  Parametrised VGA display controller: generates sync timing, fetches a framebuffer window through a synchronous-read video RAM, and overlays a crosshair cursor.

---
 rtl/dcu_window_display.sv | 219 +++++++++++++++++++++
 tb/tb_dcu_window_display.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcu_window_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcu_window_display                                           |
// | Description : Parametrised VGA display controller. Generates sync timing,  |
// |               fetches a framebuffer window through a synchronous-read      |
// |               video RAM and overlays a crosshair cursor latched per frame. |
// | Option      : define DCU_CURSOR_BLINK_EN to blink the cursor every         |
// |               2**BLINK_SH frames (adds a frame counter).                   |
// | Ports       : clk, rst (sync, active low)                                  |
// |               vdata  - RAM read data {ignored, R, G, B}                    |
// |               x, y   - cursor position in window coordinates               |
// |               vaddr  - RAM read address (row-major inside the window)      |
// |               disr/disg/disb, hs, vs, de, frame_start - VGA side, aligned  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dcu_window_display #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int WIN_X0   = 192,
  parameter int WIN_Y0   = 112,
  parameter int WIN_W    = 256,
  parameter int WIN_H    = 256,
  parameter int AW       = 16,
  parameter int MEM_LAT  = 1,
  parameter int CUR_ARM  = 2,
  parameter int BLINK_SH = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   vdata,
  input  logic [7:0]    x,
  input  logic [7:0]    y,
  output logic [AW-1:0] vaddr,
  output logic [3:0]    disr,
  output logic [3:0]    disg,
  output logic [3:0]    disb,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);
  localparam int MAXCW   = (HCW > VCW) ? HCW : VCW;
  // Signed difference width: wide enough for both counters and the 8-bit cursor.
  localparam int DW      = ((MAXCW > 8) ? MAXCW : 8) + 2;

  localparam logic [HCW-1:0] C_H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] C_H_ACT  = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] C_HS_BEG = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] C_HS_END = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HCW-1:0] C_WX0    = HCW'(WIN_X0);
  localparam logic [HCW-1:0] C_WX1    = HCW'(WIN_X0 + WIN_W);
  localparam logic [VCW-1:0] C_V_LAST = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] C_V_ACT  = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] C_VS_BEG = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] C_VS_END = VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VCW-1:0] C_WY0    = VCW'(WIN_Y0);
  localparam logic [VCW-1:0] C_WY1    = VCW'(WIN_Y0 + WIN_H);
  localparam logic signed [DW-1:0] C_ARM = DW'(CUR_ARM);

  // Control bundle carried down the pipeline: {hs, vs, de, frame_start, show}.
  // "show" means the pixel takes RAM data rather than black.
  localparam int              CTLW      = 5;
  localparam logic [CTLW-1:0] C_CTL_RST = 5'b11000;

  // Counters
  logic [HCW-1:0] hc_q, hc_d;
  logic [VCW-1:0] vc_q, vc_d;
  logic           w_h_wrap, w_v_wrap;

  // Stage 0 decode
  logic                 w_active, w_win, w_first;
  logic [HCW-1:0]       w_px;
  logic [VCW-1:0]       w_py;
  logic [7:0]           w_cx, w_cy;
  logic signed [DW-1:0] w_dx, w_dy;
  logic                 w_on_cross, w_cur, w_blank_cur;
  logic [AW-1:0]        w_addr;
  logic [CTLW-1:0]      w_ctl0;

  // Registered state
  logic [7:0]      cx_q, cy_q;
  logic [AW-1:0]   vaddr_q;
  logic [CTLW-1:0] ctl1_q;
  logic [CTLW-1:0] ctl_pipe_q [MEM_LAT];
  logic            hs_q, vs_q, de_q, fs_q;
  logic [3:0]      r_q, g_q, b_q;

  // The top nibble of a RAM word carries no colour.
  logic w_unused_vdata;
  assign w_unused_vdata = ^vdata[15:12];

  always_comb begin
    w_h_wrap = (hc_q == C_H_LAST);
    w_v_wrap = (vc_q == C_V_LAST);
    hc_d     = w_h_wrap ? '0 : hc_q + HCW'(1);
    vc_d     = vc_q;
    if (w_h_wrap) begin
      vc_d = w_v_wrap ? '0 : vc_q + VCW'(1);
    end
  end

  always_comb begin
    w_active = (hc_q < C_H_ACT) && (vc_q < C_V_ACT);
    w_win    = w_active && (hc_q >= C_WX0) && (hc_q < C_WX1) &&
               (vc_q >= C_WY0) && (vc_q < C_WY1);
    w_px     = hc_q - C_WX0;
    w_py     = vc_q - C_WY0;
    w_first  = (hc_q == '0) && (vc_q == '0);
    // The latch loads on the first pixel of the frame; that pixel already
    // uses the new position so the whole frame sees one cursor.
    w_cx     = w_first ? x : cx_q;
    w_cy     = w_first ? y : cy_q;
    // Signed distances so the arms clip at the window edge instead of wrapping.
    w_dx     = $signed(DW'(w_px) - DW'(w_cx));
    w_dy     = $signed(DW'(w_py) - DW'(w_cy));
    w_on_cross = ((w_dx == '0) && (w_dy <= C_ARM) && (w_dy >= -C_ARM)) ||
                 ((w_dy == '0) && (w_dx <= C_ARM) && (w_dx >= -C_ARM));
    w_cur    = w_on_cross && !w_blank_cur;
    w_addr   = AW'(w_py * WIN_W + w_px);
    w_ctl0   = {!((hc_q >= C_HS_BEG) && (hc_q < C_HS_END)),
                !((vc_q >= C_VS_BEG) && (vc_q < C_VS_END)),
                w_active,
                w_first,
                w_win && !w_cur};
  end

`ifdef DCU_CURSOR_BLINK_EN
  // Bit BLINK_SH toggles every 2**BLINK_SH frames; cursor hidden while set.
  logic [BLINK_SH:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_q <= '0;
    end else if (w_h_wrap && w_v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign w_blank_cur = frame_cnt_q[BLINK_SH];
`else
  assign w_blank_cur = 1'b0;

  // BLINK_SH only shapes the blink counter, which is absent in this build.
  if (BLINK_SH < 0) begin : g_no_blink
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      hc_q    <= '0;
      vc_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      vaddr_q <= '0;
      ctl1_q  <= C_CTL_RST;
      for (int i = 0; i < MEM_LAT; i++) begin
        ctl_pipe_q[i] <= C_CTL_RST;
      end
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      de_q <= 1'b0;
      fs_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      if (w_first) begin
        cx_q <= x;
        cy_q <= y;
      end
      // Address holds outside the window so the RAM sees no spurious reads.
      if (w_win) begin
        vaddr_q <= w_addr;
      end
      // Stage 1 registers the control bundle alongside vaddr; the next
      // MEM_LAT stages match the RAM latency so the output register sees
      // control and vdata for the same pixel.
      ctl1_q        <= w_ctl0;
      ctl_pipe_q[0] <= ctl1_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        ctl_pipe_q[i] <= ctl_pipe_q[i-1];
      end
      {hs_q, vs_q, de_q, fs_q} <= ctl_pipe_q[MEM_LAT-1][4:1];
      if (ctl_pipe_q[MEM_LAT-1][0]) begin
        r_q <= vdata[11:8];
        g_q <= vdata[7:4];
        b_q <= vdata[3:0];
      end else begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end
    end
  end

  assign vaddr       = vaddr_q;
  assign disr        = r_q;
  assign disg        = g_q;
  assign disb        = b_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_dcu_window_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dcu_window_display                                        |
// | Description : Self-checking bench for dcu_window_display on a small        |
// |               timing (H 8/2/2/2, V 6/1/1/1, window 2,1,4x4, MEM_LAT 1).    |
// |               A reference model queues expected outputs per pixel; a       |
// |               monitor pops and compares them. Directed hand-computed       |
// |               checks cover sync positions, window, cursor and reset.       |
// |               DCU_CURSOR_BLINK_EN selects the blink build (BLINK_SH = 1).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dcu_window_display;

  localparam int PIPE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] vdata = '0;
  logic [7:0]  x = 8'd3;
  logic [7:0]  y = 8'd3;
  logic [15:0] vaddr;
  logic [3:0]  disr, disg, disb;
  logic        hs, vs, de, frame_start;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    logic [15:0] v;
  } exp_t;

  exp_t q_pix[$];
  exp_t q_addr[$];

  dcu_window_display #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .WIN_X0(2), .WIN_Y0(1), .WIN_W(4), .WIN_H(4),
    .AW(16), .MEM_LAT(1), .CUR_ARM(2), .BLINK_SH(1)
  ) dut (
    .clk(clk), .rst(rst), .vdata(vdata), .x(x), .y(y),
    .vaddr(vaddr), .disr(disr), .disg(disg), .disb(disb),
    .hs(hs), .vs(vs), .de(de), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read, word derived from the address (top nibble junk).
  always @(posedge clk) begin
    vdata <= {4'hF, vaddr[3:0], ~vaddr[3:0], vaddr[3:0] + 4'd1};
  end

  // Reference model: tracks what the counters hold after each edge and
  // queues the expected outputs PIPE cycles (colours/sync) or 1 cycle (vaddr) out.
  int          mhc, mvc, mfc;
  int          px, py, dx, dy;
  logic [7:0]  mcx, mcy;
  logic [15:0] mhold, av;
  logic        started = 1'b0;
  logic        m_act, m_win, m_cur, m_hs, m_vs, m_fs;
  logic [11:0] m_col;

  always @(posedge clk) begin : producer
    #1;
    cyc++;
    if (!rst) begin
      q_pix.delete();
      q_addr.delete();
      mhc = 0; mvc = 0; mfc = 0;
      mcx = '0; mcy = '0; mhold = '0;
      for (int i = 0; i < PIPE; i++) q_pix.push_back('{due: cyc + i, v: 16'hC000});
      q_addr.push_back('{due: cyc, v: 16'h0000});
      started = 1'b1;
    end else if (started) begin
      mhc++;
      if (mhc == 14) begin
        mhc = 0;
        mvc++;
        if (mvc == 9) begin
          mvc = 0;
          mfc = (mfc + 1) % 4;
        end
      end
    end
    if (started) begin
      m_act = (mhc < 8) && (mvc < 6);
      m_win = m_act && (mhc >= 2) && (mhc < 6) && (mvc >= 1) && (mvc < 5);
      px = mhc - 2;
      py = mvc - 1;
      if (mhc == 0 && mvc == 0) begin
        mcx = x;
        mcy = y;
      end
      dx = px - int'(mcx);
      dy = py - int'(mcy);
      m_cur = (dx == 0 && dy >= -2 && dy <= 2) || (dy == 0 && dx >= -2 && dx <= 2);
`ifdef DCU_CURSOR_BLINK_EN
      if (mfc >= 2) m_cur = 1'b0;
`endif
      av    = 16'(py * 4 + px);
      m_hs  = !(mhc >= 10 && mhc < 12);
      m_vs  = (mvc != 7);
      m_fs  = (mhc == 0 && mvc == 0);
      m_col = (m_win && !m_cur) ? {av[3:0], ~av[3:0], av[3:0] + 4'd1} : 12'h000;
      q_pix.push_back('{due: cyc + PIPE, v: {m_hs, m_vs, m_act, m_fs, m_col}});
      if (m_win) mhold = av;
      q_addr.push_back('{due: cyc + 1, v: mhold});
    end
  end

  exp_t        e;
  logic [15:0] act;

  always @(posedge clk) begin : monitor
    #2;
    while (q_pix.size() > 0 && q_pix[0].due <= cyc) begin
      e   = q_pix.pop_front();
      act = {hs, vs, de, frame_start, disr, disg, disb};
      n_checks++;
      if (e.due != cyc || act !== e.v) begin
        n_fail++;
        $display("FAIL pixel cyc=%0d due=%0d {hs,vs,de,fs,rgb} actual=%h required=%h",
                 cyc, e.due, act, e.v);
      end
    end
    while (q_addr.size() > 0 && q_addr[0].due <= cyc) begin
      e = q_addr.pop_front();
      n_checks++;
      if (e.due != cyc || vaddr !== e.v) begin
        n_fail++;
        $display("FAIL vaddr cyc=%0d due=%0d actual=%h required=%h", cyc, e.due, vaddr, e.v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] r);
    n_checks++;
    if (a !== r) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, a, r);
    end
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int R, R2;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    R   = cyc;                      // last reset edge; counters at (0,0) in cycle R

    at_cycle(R);
    check("reset_hs_vs_de_fs", {hs, vs, de, frame_start}, 4'b1100);
    check("reset_vaddr", vaddr, 16'h0000);
    at_cycle(R + 2);   check("fs_before", frame_start, 1'b0);
    at_cycle(R + 3);
    check("fs_pulse", frame_start, 1'b1);
    check("origin_de", de, 1'b1);
    check("origin_black", {disr, disg, disb}, 12'h000);
    at_cycle(R + 4);   check("fs_after", frame_start, 1'b0);
    at_cycle(R + 12);  check("hs_hc9", hs, 1'b1);
    at_cycle(R + 13);  check("hs_hc10", hs, 1'b0);
    at_cycle(R + 14);  check("hs_hc11", hs, 1'b0);
    at_cycle(R + 15);  check("hs_hc12", hs, 1'b1);
    at_cycle(R + 27);  check("hs_line2", hs, 1'b0);
    at_cycle(R + 32);  check("vaddr_px1_py1", vaddr, 16'h0005);
    at_cycle(R + 34);
    check("win_px1_py1_rgb", {disr, disg, disb}, 12'h5A6);
    check("win_px1_py1_de", de, 1'b1);
    x = 8'd1;
    y = 8'd1;
    at_cycle(R + 100); check("vs_vc6", vs, 1'b1);
    at_cycle(R + 101); check("vs_vc7_start", vs, 1'b0);
    at_cycle(R + 114); check("vs_vc7_end", vs, 1'b0);
    at_cycle(R + 115); check("vs_vc8", vs, 1'b1);
    at_cycle(R + 128); check("fs_frame1_before", frame_start, 1'b0);
    at_cycle(R + 129); check("fs_frame1", frame_start, 1'b1);
    at_cycle(R + 166);
    x = 8'd3;                        // mid-frame move: takes effect next frame
    at_cycle(R + 175); check("f1_px2_py2_data", {disr, disg, disb}, 12'hA5B);
    at_cycle(R + 188);
    check("f1_cursor_px1_py3", {disr, disg, disb}, 12'h000);
    check("f1_cursor_de", de, 1'b1);
    at_cycle(R + 190); check("f1_px3_py3_data", {disr, disg, disb}, 12'hF00);
`ifdef DCU_CURSOR_BLINK_EN
    at_cycle(R + 288); check("f2_blink_off_px3_py1", {disr, disg, disb}, 12'h788);
`else
    at_cycle(R + 288); check("f2_cursor_px3_py1", {disr, disg, disb}, 12'h000);
`endif
    at_cycle(R + 314); check("f2_px1_py3_data", {disr, disg, disb}, 12'hD2E);
    at_cycle(R + 320);
    check("vaddr_hold", vaddr, 16'h000F);
    rst = 1'b0;
    at_cycle(R + 321);
    rst = 1'b1;
    R2  = cyc;
    check("midreset_sync", {hs, vs, de, frame_start}, 4'b1100);
    check("midreset_rgb", {disr, disg, disb}, 12'h000);
    check("midreset_vaddr", vaddr, 16'h0000);
    at_cycle(R2 + 2);  check("restart_fs_before", frame_start, 1'b0);
    at_cycle(R2 + 3);  check("restart_fs", frame_start, 1'b1);
    at_cycle(R2 + 5 * 126 + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
